// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - parallel-to-serial MSB-first frame loader with one-word holding buffer
// Optional PARITY_EN macro appends an even-parity bit after the LSB of every frame.
module serial_word_loader #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             si,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

`ifdef PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [1:0]           state, state_n;
    logic [WIDTH-1:0]     buf_q;
    logic                 buf_full, buf_full_n;
    logic [FRAME_LEN-1:0] shreg, shreg_n, frame;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [GW-1:0]        gap_cnt, gap_cnt_n;
    logic                 si_n, accept, load, frame_end, gap_end;

    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [WIDTH-1:0] w);
`ifdef PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Gated by rst so the upstream sees "not ready" for as long as reset is held.
    assign pi_ready  = !buf_full && !rst;
    assign accept    = pi_valid && pi_ready;
    assign frame_end = (state == S_SHIFT) && (bit_cnt == BW'(FRAME_LEN));
    assign gap_end   = (state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES));
    // A waiting word is loaded straight out of the frame end (no gap) or gap end, keeping the gap exact.
    assign load      = buf_full && ((state == S_IDLE) || (frame_end && (GAP_CYCLES == 0)) || gap_end);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        si_n      = 1'b0;
        frame     = make_frame(buf_q);
        if (load) begin
            si_n      = frame[FRAME_LEN-1];
            shreg_n   = frame << 1;
            bit_cnt_n = BW'(1);
            gap_cnt_n = '0;
            state_n   = S_SHIFT;
        end else begin
            case (state)
                S_SHIFT: begin
                    if (frame_end) begin
                        bit_cnt_n = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n   = S_GAP;
                            gap_cnt_n = GW'(1);
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        si_n      = shreg[FRAME_LEN-1];
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state_n   = S_IDLE;
                        gap_cnt_n = '0;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        buf_full_n = accept ? 1'b1 : (load ? 1'b0 : buf_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            buf_q    <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            si       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            buf_full <= buf_full_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            gap_cnt  <= gap_cnt_n;
            si       <= si_n;
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_SHIFT) && (bit_cnt_n == BW'(FRAME_LEN));
            if (accept) begin
                buf_q <= pi;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - directed self-checking bench for serial_word_loader (gap 2 and gap 0 instances)
module tb_serial_word_loader;

`ifdef PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pi, pi1;
    logic       pi_valid, pv1;
    logic       si, busy, done, pi_ready;
    logic       si1, busy1, done1, rdy1;
    logic       acc;
    int         checks = 0;
    int         errors = 0;
    int         dn, ones;
    logic       exp_q[$];

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready),
        .si(si), .busy(busy), .done(done)
    );

    serial_word_loader #(.WIDTH(8), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst), .pi(pi1), .pi_valid(pv1), .pi_ready(rdy1),
        .si(si1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic run_frame(input string tag, input logic [7:0] w);
        int n;
        exp_q.delete();
        push_word(w);
        n = exp_q.size();
        pi = w;
        pi_valid = 1'b1;
        chk({tag, "_rdy"}, pi_ready, 1);
        step();
        pi_valid = 1'b0;
        chk({tag, "_rdy_full"}, pi_ready, 0);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_si"}, si, exp_q[i]);
            chk({tag, "_done"}, done, (i == n - 1));
            chk({tag, "_busy"}, busy, 1);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk({tag, "_gap_si"}, si, 0);
            chk({tag, "_gap_busy"}, busy, 1);
            chk({tag, "_gap_done"}, done, 0);
        end
        step();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_rdy"}, pi_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        pi = 8'h00;
        pi1 = 8'h00;
        pi_valid = 1'b0;
        pv1 = 1'b0;

        repeat (3) begin
            step();
            chk("rst_si", si, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rdy", pi_ready, 0);
            chk("rst_si_nogap", si1, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", pi_ready, 1);
        chk("post_rst_rdy_nogap", rdy1, 1);

        run_frame("a5", 8'hA5);
        run_frame("w07", 8'h07);
        run_frame("w03", 8'h03);

        // Back-to-back words with pi_valid held: second word waits in the buffer
        exp_q.delete();
        push_word(8'hFF);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        push_word(8'h01);
        pi = 8'hFF;
        pi_valid = 1'b1;
        step();
        pi = 8'h01;
        dn = 0;
        for (int k = 1; k <= exp_q.size(); k++) begin
            acc = pi_valid && pi_ready;
            step();
            if (acc) pi_valid = 1'b0;
            chk("b2b_si", si, exp_q[k-1]);
            if (done) dn++;
            if (k == 3) chk("b2b_rdy_held", pi_ready, 0);
            if (k == FL + 2) chk("b2b_rdy_gap", pi_ready, 0);
            if (k == FL + 3) chk("b2b_rdy_drained", pi_ready, 1);
        end
        chk("b2b_done_count", dn, 2);
        chk("b2b_valid_taken", pi_valid, 0);
        repeat (3) step();
        chk("b2b_idle_busy", busy, 0);

        // Reset mid-frame with a second word buffered
        pi = 8'hC3;
        pi_valid = 1'b1;
        step();
        pi_valid = 1'b0;
        step();
        chk("abort_bit1", si, 1);
        pi = 8'hFF;
        pi_valid = 1'b1;
        step();
        pi_valid = 1'b0;
        chk("abort_bit2", si, 1);
        chk("abort_buf_full", pi_ready, 0);
        step();
        chk("abort_bit3", si, 0);
        rst = 1'b1;
        #1;
        chk("abort_rdy_in_rst", pi_ready, 0);
        step();
        chk("abort_si", si, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        dn = 0;
        ones = 0;
        repeat (14) begin
            step();
            if (si) ones++;
            if (done || busy) dn++;
        end
        chk("abort_no_frame_si", ones, 0);
        chk("abort_no_frame_activity", dn, 0);
        chk("abort_rdy_after", pi_ready, 1);

        // Zero-gap instance: contiguous frames
        exp_q.delete();
        push_word(8'hAA);
        push_word(8'h55);
        pi1 = 8'hAA;
        pv1 = 1'b1;
        step();
        pi1 = 8'h55;
        dn = 0;
        for (int k = 1; k <= exp_q.size(); k++) begin
            acc = pv1 && rdy1;
            step();
            if (acc) pv1 = 1'b0;
            chk("nogap_si", si1, exp_q[k-1]);
            chk("nogap_busy", busy1, 1);
            if (done1) dn++;
        end
        chk("nogap_done_count", dn, 2);
        step();
        chk("nogap_idle_busy", busy1, 0);
        chk("nogap_idle_si", si1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
